// File: rtl/alu_ram_arbiter_pkg.sv
// Shared types for the stateful ALU RAM arbiter.
// Owner tags, FSM states and width defaults.
package alu_ram_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH      = 5;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_RD_LAT          = 2;
  localparam int DEF_STALL_CNT_WIDTH = 16;

  localparam logic OWN_DP  = 1'b0;
  localparam logic OWN_CFG = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARB      = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_ram_rd_tracker.sv
// Read tag pipeline with write-history forwarding.
// Steers port-B data back to the owner of each read.
module alu_ram_rd_tracker
  import alu_ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_LAT     = DEF_RD_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en_i,
  input  logic                  rd_own_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [DATA_WIDTH-1:0] ram_doutb_i,
  output logic                  dp_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] dp_rsp_data_o,
  output logic                  cfg_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] cfg_rsp_data_o
);

  logic [RD_LAT-1:0]     wh_v_q;
  logic [ADDR_WIDTH-1:0] wh_a_q [RD_LAT];
  logic [DATA_WIDTH-1:0] wh_d_q [RD_LAT];

  logic [RD_LAT-1:0]     tg_v_q;
  logic [RD_LAT-1:0]     tg_o_q;
  logic [RD_LAT-1:0]     tg_f_q;
  logic [DATA_WIDTH-1:0] tg_d_q [RD_LAT];

  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [DATA_WIDTH-1:0] out_data;

  // Youngest write to the read address inside the RAM's blind window wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = RD_LAT - 2; i >= 0; i--) begin
      if (wh_v_q[i] && wh_a_q[i] == rd_addr_i) begin
        fwd_hit  = 1'b1;
        fwd_data = wh_d_q[i];
      end
    end
    if (wr_en_i && wr_addr_i == rd_addr_i) begin
      fwd_hit  = 1'b1;
      fwd_data = wr_data_i;
    end
  end

  // Shift tag and write-history valid bits; cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tg_v_q <= '0;
      tg_o_q <= '0;
      tg_f_q <= '0;
      wh_v_q <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        tg_v_q[i] <= tg_v_q[i-1];
        tg_o_q[i] <= tg_o_q[i-1];
        tg_f_q[i] <= tg_f_q[i-1];
        wh_v_q[i] <= wh_v_q[i-1];
      end
      tg_v_q[0] <= rd_en_i;
      tg_o_q[0] <= rd_own_i;
      tg_f_q[0] <= rd_en_i & fwd_hit;
      wh_v_q[0] <= wr_en_i;
    end
  end

  // Shift the data payloads alongside the valid bits.
  always_ff @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) begin
      tg_d_q[i] <= tg_d_q[i-1];
      wh_a_q[i] <= wh_a_q[i-1];
      wh_d_q[i] <= wh_d_q[i-1];
    end
    tg_d_q[0] <= fwd_data;
    wh_a_q[0] <= wr_addr_i;
    wh_d_q[0] <= wr_data_i;
  end

  // Pick forwarded or RAM data and route it to the owning requester.
  always_comb begin
    out_data = tg_f_q[RD_LAT-1] ? tg_d_q[RD_LAT-1] : ram_doutb_i;
    dp_rsp_valid_o  = tg_v_q[RD_LAT-1] & (tg_o_q[RD_LAT-1] == OWN_DP);
    cfg_rsp_valid_o = tg_v_q[RD_LAT-1] & (tg_o_q[RD_LAT-1] == OWN_CFG);
    dp_rsp_data_o   = dp_rsp_valid_o ? out_data : '0;
    cfg_rsp_data_o  = cfg_rsp_valid_o ? out_data : '0;
  end

endmodule

// File: rtl/alu_ram_arbiter.sv
// Shares the stateful ALU RAM between packet and control paths.
// Packet path always wins; control waits for a free port.
module alu_ram_arbiter
  import alu_ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int RD_LAT          = DEF_RD_LAT,
  parameter int STALL_CNT_WIDTH = DEF_STALL_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       dp_valid,
  input  logic                       dp_we,
  input  logic [ADDR_WIDTH-1:0]      dp_addr,
  input  logic [DATA_WIDTH-1:0]      dp_wdata,
  output logic                       dp_rsp_valid,
  output logic [DATA_WIDTH-1:0]      dp_rsp_data,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic                       cfg_we,
  input  logic [ADDR_WIDTH-1:0]      cfg_addr,
  input  logic [DATA_WIDTH-1:0]      cfg_wdata,
  output logic                       cfg_rsp_valid,
  output logic [DATA_WIDTH-1:0]      cfg_rsp_data,
  output logic [STALL_CNT_WIDTH-1:0] cfg_stall_cnt,
  output logic                       ram_wea,
  output logic [ADDR_WIDTH-1:0]      ram_addra,
  output logic [DATA_WIDTH-1:0]      ram_dina,
  output logic [ADDR_WIDTH-1:0]      ram_addrb,
  input  logic [DATA_WIDTH-1:0]      ram_doutb
);

  state_e state_q, state_d;

  logic                       h_we_q, h_we_d;
  logic [ADDR_WIDTH-1:0]      h_addr_q, h_addr_d;
  logic [DATA_WIDTH-1:0]      h_data_q, h_data_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
  logic [ADDR_WIDTH-1:0]      addra_q, addrb_q;
  logic [DATA_WIDTH-1:0]      dina_q;

  logic dp_st, dp_ld, in_arb;
  logic wr_gnt, rd_gnt;
  logic rd_en, rd_own;

  // Classify this cycle's packet request and control grant.
  always_comb begin
    dp_st  = rst_n & dp_valid & dp_we;
    dp_ld  = rst_n & dp_valid & ~dp_we;
    in_arb = rst_n & (state_q == ARB);
    wr_gnt = in_arb & h_we_q & ~dp_st;
    rd_gnt = in_arb & ~h_we_q & ~dp_ld;
  end

  // Drive both RAM ports; unused port fields hold their last value.
  always_comb begin
    ram_wea   = dp_st | wr_gnt;
    ram_addra = addra_q;
    ram_dina  = dina_q;
    ram_addrb = addrb_q;
    rd_en     = dp_ld | rd_gnt;
    rd_own    = dp_ld ? OWN_DP : OWN_CFG;
    unique case (1'b1)
      dp_st: begin
        ram_addra = dp_addr;
        ram_dina  = dp_wdata;
      end
      wr_gnt: begin
        ram_addra = h_addr_q;
        ram_dina  = h_data_q;
      end
      default: ;
    endcase
    unique case (1'b1)
      dp_ld:   ram_addrb = dp_addr;
      rd_gnt:  ram_addrb = h_addr_q;
      default: ;
    endcase
  end

  // Control FSM: capture, arbitrate, wait for read data.
  always_comb begin
    state_d   = state_q;
    h_we_d    = h_we_q;
    h_addr_d  = h_addr_q;
    h_data_d  = h_data_q;
    stall_d   = stall_q;
    cfg_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready = rst_n;
        if (cfg_valid) begin
          h_we_d   = cfg_we;
          h_addr_d = cfg_addr;
          h_data_d = cfg_wdata;
          state_d  = ARB;
        end
      end
      ARB: begin
        if (wr_gnt) begin
          state_d = IDLE;
        end else if (rd_gnt) begin
          state_d = WAIT_RSP;
        end else if (~&stall_q) begin
          stall_d = stall_q + 1'b1;
        end
      end
      WAIT_RSP: begin
        if (cfg_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, holding register, stall counter and held port fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      h_we_q   <= 1'b0;
      h_addr_q <= '0;
      h_data_q <= '0;
      stall_q  <= '0;
      addra_q  <= '0;
      dina_q   <= '0;
      addrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      h_we_q   <= h_we_d;
      h_addr_q <= h_addr_d;
      h_data_q <= h_data_d;
      stall_q  <= stall_d;
      if (ram_wea) begin
        addra_q <= ram_addra;
        dina_q  <= ram_dina;
      end
      if (rd_en) addrb_q <= ram_addrb;
    end
  end

  assign cfg_stall_cnt = stall_q;

  alu_ram_rd_tracker #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .RD_LAT    (RD_LAT)
  ) u_trk (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_en_i        (rd_en),
    .rd_own_i       (rd_own),
    .rd_addr_i      (ram_addrb),
    .wr_en_i        (ram_wea),
    .wr_addr_i      (ram_addra),
    .wr_data_i      (ram_dina),
    .ram_doutb_i    (ram_doutb),
    .dp_rsp_valid_o (dp_rsp_valid),
    .dp_rsp_data_o  (dp_rsp_data),
    .cfg_rsp_valid_o(cfg_rsp_valid),
    .cfg_rsp_data_o (cfg_rsp_data)
  );

endmodule
